cubic_feeder: RTL and testbench

CUBIC_FEEDER -- requirements
Module: cubic_feeder

---
 rtl/cubic_feeder.sv | 157 +++++++++++++++
 tb/tb_cubic_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cubic_feeder.sv
// Feeds a Catmull-Rom cubic engine: streams four neighbouring pixels and {t, t^2, t^3}
// per output sample along one image line, and forwards the engine's result.
module cubic_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] base_addr,
  input  logic [8:0]  width,
  input  logic [15:0] start_pos,
  input  logic [15:0] step,
  input  logic [7:0]  count,
  output logic        mem_rd,
  output logic [13:0] mem_addr,
  input  logic [7:0]  mem_q,
  output logic [23:0] X_out,
  output logic [7:0]  P_out,
  output logic [2:0]  cycle_cnt,
  input  logic [7:0]  eng_out,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t       state, next_state;
  logic [2:0]   phase;
  logic         flush_cnt;
  logic         first_grp;
  logic         zero_done;
  logic [13:0]  base_r;
  logic [8:0]   width_r;
  logic [15:0]  pos_r;
  logic [15:0]  step_r;
  logic [7:0]   remain;
  logic [23:0]  x_hold;

  logic         accept;
  logic [7:0]   t, t2, t3;
  logic signed [10:0] raw;
  logic [8:0]   wmax;
  logic [7:0]   idx;

  // A zero-length run still owes its done pulse, so starts are held off until it is out.
  assign accept = (state == IDLE) && start && !zero_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && count != 8'd0) next_state = RUN;
      RUN:     if (phase == 3'd4 && remain == 8'd1) next_state = FLUSH;
      FLUSH:   if (flush_cnt) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= 3'd0;
      flush_cnt <= 1'b0;
      first_grp <= 1'b0;
      zero_done <= 1'b0;
      base_r    <= 14'd0;
      width_r   <= 9'd0;
      pos_r     <= 16'd0;
      step_r    <= 16'd0;
      remain    <= 8'd0;
      x_hold    <= 24'd0;
    end else begin
      x_hold    <= X_out;
      zero_done <= 1'b0;
      if (accept) begin
        base_r    <= base_addr;
        width_r   <= width;
        pos_r     <= start_pos;
        step_r    <= step;
        remain    <= count;
        phase     <= 3'd0;
        first_grp <= 1'b1;
        zero_done <= (count == 8'd0);
      end else if (state == RUN) begin
        if (phase == 3'd4) begin
          phase     <= 3'd0;
          pos_r     <= pos_r + step_r;
          remain    <= remain - 8'd1;
          first_grp <= 1'b0;
        end else begin
          phase <= phase + 3'd1;
        end
      end else if (state == FLUSH) begin
        flush_cnt <= ~flush_cnt;
      end
    end
  end

  // Powers of the fraction, each rounded to nearest in Q0.8.
  always_comb begin
    t  = pos_r[7:0];
    t2 = 8'((({8'd0, t} * {8'd0, t}) + 16'd128) >> 8);
    t3 = 8'((({8'd0, t2} * {8'd0, t}) + 16'd128) >> 8);
  end

  // Neighbour index i-1+phase, clamped to the line with signed compare.
  always_comb begin
    raw  = $signed({3'b000, pos_r[15:8]}) + $signed({8'd0, phase}) - 11'sd1;
    wmax = width_r - 9'd1;
    if (raw < 11'sd0)
      idx = 8'd0;
    else if (raw > $signed({2'b00, wmax}))
      idx = wmax[7:0];
    else
      idx = raw[7:0];
  end

  always_comb begin
    cycle_cnt = 3'd7;
    mem_rd    = 1'b0;
    mem_addr  = 14'd0;
    X_out     = x_hold;
    res_valid = 1'b0;
    busy      = 1'b0;
    done      = zero_done;
    case (state)
      RUN: begin
        cycle_cnt = phase;
        busy      = 1'b1;
        if (phase != 3'd4) begin
          mem_rd   = 1'b1;
          mem_addr = base_r + {6'd0, idx};
        end
        if (phase == 3'd0) X_out = {t, t2, t3};
        if (phase == 3'd1 && !first_grp) res_valid = 1'b1;
      end
      FLUSH: begin
        if (!flush_cnt) begin
          cycle_cnt = 3'd0;
          X_out     = 24'd0;
          busy      = 1'b1;
        end else begin
          res_valid = 1'b1;
          done      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign res_data = res_valid ? eng_out : 8'd0;
  assign P_out    = mem_q;

endmodule

// File: tb/tb_cubic_feeder.sv
// Bench for cubic_feeder: image memory and Catmull-Rom engine models attached, with a
// golden model computing every expected address, power and result from the line geometry.
module tb_cubic_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [8:0]  width = '0;
  logic [15:0] start_pos = '0;
  logic [15:0] step = '0;
  logic [7:0]  count = '0;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [7:0]  mem_q = '0;
  logic [23:0] X_out;
  logic [7:0]  P_out;
  logic [2:0]  cycle_cnt;
  logic [7:0]  eng_out = '0;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [7:0]  img [0:16383];
  logic [23:0] eng_x = '0;
  logic [7:0]  eng_p [0:2];

  cubic_feeder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .width(width),
    .start_pos(start_pos), .step(step), .count(count), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_q(mem_q), .X_out(X_out), .P_out(P_out),
    .cycle_cnt(cycle_cnt), .eng_out(eng_out), .res_valid(res_valid),
    .res_data(res_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int pow2(int t);
    return (t * t + 128) / 256;
  endfunction

  function automatic int pow3(int t);
    return (pow2(t) * t + 128) / 256;
  endfunction

  function automatic int clampIdx(int v, int w);
    if (v < 0) return 0;
    if (v > w - 1) return w - 1;
    return v;
  endfunction

  // Catmull-Rom with a half-weight: p1 + (a*t + b*t^2 + c*t^3)/512, rounded and saturated.
  function automatic int catmull(int t, int t2, int t3, int p0, int p1, int p2, int p3);
    int acc;
    int r;
    acc = 512 * p1 + (p2 - p0) * t + (2 * p0 - 5 * p1 + 4 * p2 - p3) * t2
        + (3 * p1 - p0 - 3 * p2 + p3) * t3;
    r = (acc + 256) >>> 9;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_q <= img[mem_addr];
  end

  // Engine: latches X in phase 0, pixels in phases 1..3, produces its result after phase 4.
  always @(posedge clk) begin
    case (cycle_cnt)
      3'd0: eng_x <= X_out;
      3'd1: eng_p[0] <= P_out;
      3'd2: eng_p[1] <= P_out;
      3'd3: eng_p[2] <= P_out;
      3'd4: eng_out <= 8'(catmull(int'(eng_x[23:16]), int'(eng_x[15:8]), int'(eng_x[7:0]),
                                  int'(eng_p[0]), int'(eng_p[1]), int'(eng_p[2]), int'(P_out)));
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cyc"}, int'(cycle_cnt), 7);
    checkOutput({tag, "_rd"}, int'(mem_rd), 0);
    checkOutput({tag, "_addr"}, int'(mem_addr), 0);
    checkOutput({tag, "_x"}, int'(X_out), 0);
    checkOutput({tag, "_rv"}, int'(res_valid), 0);
    checkOutput({tag, "_data"}, int'(res_data), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  // One run, checked every cycle from c0 through the done cycle; returns in the cycle after done.
  task automatic applyStimulus(input int b, input int w, input int sp, input int st, input int n,
                               input bit noise, input bit x_chk, input int x_exp);
    int gold [256];
    int pos, i, t, g, ph;
    checkOutput("pre_busy", int'(busy), 0);
    checkOutput("pre_cyc", int'(cycle_cnt), 7);
    for (int k = 0; k < n; k++) begin
      pos = (sp + k * st) % 65536;
      i = pos / 256;
      t = pos % 256;
      gold[k] = catmull(t, pow2(t), pow3(t),
                        int'(img[(b + clampIdx(i - 1, w)) % 16384]),
                        int'(img[(b + clampIdx(i, w)) % 16384]),
                        int'(img[(b + clampIdx(i + 1, w)) % 16384]),
                        int'(img[(b + clampIdx(i + 2, w)) % 16384]));
    end
    base_addr = 14'(b);
    width = 9'(w);
    start_pos = 16'(sp);
    step = 16'(st);
    count = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      checkOutput("zero_done", int'(done), 1);
      checkOutput("zero_busy", int'(busy), 0);
      checkOutput("zero_rd", int'(mem_rd), 0);
      @(negedge clk);
      checkOutput("zero_done_end", int'(done), 0);
      checkOutput("zero_rd_end", int'(mem_rd), 0);
      return;
    end
    for (int k = 0; k < 5 * n + 2; k++) begin
      if (k < 5 * n) begin
        g = k / 5;
        ph = k % 5;
        pos = (sp + g * st) % 65536;
        i = pos / 256;
        t = pos % 256;
        checkOutput("run_cyc", int'(cycle_cnt), ph);
        checkOutput("run_rd", int'(mem_rd), (ph < 4) ? 1 : 0);
        if (ph < 4)
          checkOutput("run_addr", int'(mem_addr), (b + clampIdx(i - 1 + ph, w)) % 16384);
        if (ph == 0)
          checkOutput("run_x", int'(X_out), (t << 16) | (pow2(t) << 8) | pow3(t));
        if (x_chk && k == 0)
          checkOutput("x_const", int'(X_out), x_exp);
        checkOutput("run_busy", int'(busy), 1);
        checkOutput("run_done", int'(done), 0);
        checkOutput("run_rv", int'(res_valid), (ph == 1 && g > 0) ? 1 : 0);
        if (ph == 1 && g > 0)
          checkOutput("run_data", int'(res_data), gold[g - 1]);
      end else if (k == 5 * n) begin
        checkOutput("flush0_cyc", int'(cycle_cnt), 0);
        checkOutput("flush0_rd", int'(mem_rd), 0);
        checkOutput("flush0_x", int'(X_out), 0);
        checkOutput("flush0_busy", int'(busy), 1);
        checkOutput("flush0_rv", int'(res_valid), 0);
        checkOutput("flush0_done", int'(done), 0);
      end else begin
        checkOutput("flush1_cyc", int'(cycle_cnt), 7);
        checkOutput("flush1_rd", int'(mem_rd), 0);
        checkOutput("flush1_rv", int'(res_valid), 1);
        checkOutput("flush1_data", int'(res_data), gold[n - 1]);
        checkOutput("flush1_done", int'(done), 1);
        checkOutput("flush1_busy", int'(busy), 0);
      end
      if (noise && k == 2) begin
        start = 1'b1;
        base_addr = 14'h3FFF;
        start_pos = 16'h1234;
        count = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) img[a] = 8'($urandom);
    eng_p[0] = '0;
    eng_p[1] = '0;
    eng_p[2] = '0;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("rst_hold");
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkReset("post_rst");
    end

    applyStimulus(14'h200, 256, 16'h0380, 16'h0100, 1, 1'b0, 1'b1, 24'h804020);
    applyStimulus(14'h200, 256, 16'h03FF, 16'h0100, 1, 1'b0, 1'b1, 24'hFFFEFD);
    applyStimulus(14'h100, 16, 16'h0000, 16'h0100, 1, 1'b0, 1'b0, 0);
    applyStimulus(14'h100, 16, 16'h0F00, 16'h0100, 1, 1'b0, 1'b0, 0);
    applyStimulus(14'h100, 16, 16'h0240, 16'h0100, 3, 1'b1, 1'b0, 0);
    applyStimulus(14'h100, 16, 16'h0240, 16'h0100, 0, 1'b0, 1'b0, 0);
    applyStimulus(14'h3FFE, 1, 16'h0080, 16'h0040, 2, 1'b0, 1'b0, 0);

    for (int r = 0; r < 12; r++) begin
      applyStimulus(int'($urandom_range(0, 16383)), int'($urandom_range(1, 256)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(1, 5)), r[0], 1'b0, 0);
    end

    // Abort mid-run: outputs must fall to reset values without waiting for a clock.
    base_addr = 14'h040;
    width = 9'd32;
    start_pos = 16'h0500;
    step = 16'h0100;
    count = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("pre_abort_busy", int'(busy), 1);
    rst = 1'b0;
    #1 checkReset("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkReset("post_abort");
    end
    applyStimulus(14'h040, 32, 16'h1F80, 16'h0055, 2, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
